uart_tfifo: RTL and testbench
=============================

UART_TFIFO -- requirements
Module: uart_tfifo

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 8 (`UART_FIFO_WIDTH`), meaning data word width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16 (`UART_FIFO_DEPTH`), meaning number of storage entries.
REQ-003 SHALL have parameter FIFO_POINTER_W, default 4 (`UART_FIFO_POINTER_W`), meaning read/write pointer width.
REQ-004 SHALL have parameter FIFO_COUNTER_W, default 5 (`UART_FIFO_COUNTER_W`), meaning occupancy counter width.
REQ-005 SHALL have one clock and an asynchronous, active-high reset.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 wb_rst_i  input  1  asynchronous active-high reset.
REQ-008 data_in  input  FIFO_WIDTH  word written on push.
REQ-009 push  input  1  write request, sampled on the clk rising edge.
REQ-010 pop  input  1  read/advance request, sampled on the clk rising edge.
REQ-011 fifo_reset  input  1  synchronous flush of contents and status.
REQ-012 reset_status  input  1  synchronous clear of overrun only.
REQ-013 data_out  output  FIFO_WIDTH  head entry (show-ahead, combinational from storage).
REQ-014 count  output  FIFO_COUNTER_W  current occupancy, 0..16.
REQ-015 overrun  output  1  sticky flag set by a push into a full FIFO.

Function
REQ-016 SHALL be a 16x8 circular FIFO with 4-bit write pointer (top) and read pointer (bottom), both wrapping 15->0.
REQ-017 data_out SHALL always equal storage[bottom], with no read latency, so the consumer samples data_out in the same cycle it asserts pop.
REQ-018 Push with count<16: store data_in at top, top+1, count+1 at the next edge.
REQ-019 Pop with count>0: bottom+1, count-1 at the next edge.
REQ-020 Pop with count==0 SHALL be ignored (pointers and count unchanged).
REQ-021 Push with count==16 and no pop SHALL drop data_in, leave pointers and count unchanged, and set overrun.
REQ-022 Simultaneous push and pop with count in 1..16: store at top, advance both pointers, count unchanged, overrun unchanged.
REQ-023 Simultaneous push and pop with count==0: perform the push only (count becomes 1).
REQ-024 overrun SHALL stay set until reset_status, fifo_reset or wb_rst_i clears it; a clear SHALL win over a same-cycle set.
REQ-025 fifo_reset SHALL zero top, bottom, count and overrun at the next edge, taking priority over same-cycle push/pop; storage contents may remain.
REQ-026 count SHALL be registered, updating on the edge after the push/pop that changes it.

Reset
REQ-027 wb_rst_i SHALL asynchronously force top=0, bottom=0, count=0, overrun=0, and all storage entries to 0, so data_out=0.
REQ-028 Reset asserted mid-operation SHALL discard all pending contents with no partial update.

Structure
REQ-029 FIFO_WIDTH/DEPTH/POINTER_W/COUNTER_W values SHALL come from the shared uart_defines constants, not be hard-coded.
REQ-030 The storage array SHALL be one sub-module, uart_tfifo_mem, with one write port and one asynchronous read port; pointer, count and flag logic stay in uart_tfifo.

Verification
REQ-031 Reset, then push 0xA5: next cycle count=1, data_out=0xA5, overrun=0.
REQ-032 Push 0x01..0x10 (16 words), then pop 16 times: data_out reads 0x01..0x10 in order, count ends at 0, and a further pop leaves count=0.
REQ-033 With the FIFO full, push 0xFF: count=16, overrun=1, and 0xFF is never read; then reset_status makes overrun=0.
REQ-034 count=3, assert push(0x55)+pop together: count stays 3, head advances, 0x55 appears after the two older words.
REQ-035 count=7 with overrun=1, pulse fifo_reset together with push: count=0 and overrun=0 next cycle, and the pushed word is discarded.
REQ-036 Assert wb_rst_i asynchronously mid-stream: count, overrun and data_out go to 0 before the next clk edge.

Source files
------------

// File: rtl/uart_tfifo_pkg.sv
// Shared UART transmit-FIFO constants and small helpers.
// Every FIFO dimension used by uart_tfifo and its storage comes from here.
package uart_tfifo_pkg;

   localparam int UART_FIFO_WIDTH     = 8;   // data word width
   localparam int UART_FIFO_DEPTH     = 16;  // number of storage entries
   localparam int UART_FIFO_POINTER_W = 4;   // read/write pointer width
   localparam int UART_FIFO_COUNTER_W = 5;   // occupancy counter width (0..DEPTH)

   // Kind of pointer/count movement requested in one cycle.
   typedef enum logic [1:0] {
      FIFO_IDLE = 2'b00,
      FIFO_POP  = 2'b01,
      FIFO_PUSH = 2'b10,
      FIFO_BOTH = 2'b11
   } fifo_op_e;

endpackage

// File: rtl/uart_tfifo_mem.sv
// Storage array for the UART transmit FIFO: one write port and one
// asynchronous (show-ahead) read port. Entries are individually cleared
// by the system reset so the head reads zero straight out of reset.
module uart_tfifo_mem
   import uart_tfifo_pkg::*;
#(
   parameter int WIDTH  = UART_FIFO_WIDTH,
   parameter int DEPTH  = UART_FIFO_DEPTH,
   parameter int ADDR_W = UART_FIFO_POINTER_W
) (
   input  logic              clk,
   input  logic              wb_rst_i,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] storage_reg [DEPTH];

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         // Each entry loads the write data when addressed; cleared by reset.
         always_ff @(posedge clk or posedge wb_rst_i) begin
            if (wb_rst_i)
               storage_reg[gi] <= '0;
            else if (we && (waddr == ADDR_W'(gi)))
               storage_reg[gi] <= wdata;
         end
      end
   endgenerate

   // Head entry is visible without read latency.
   assign rdata = storage_reg[raddr];

endmodule

// File: rtl/uart_tfifo.sv
// UART transmit FIFO: circular buffer with show-ahead output, registered
// occupancy count and a sticky overrun flag. The storage lives in
// uart_tfifo_mem; pointer, count and flag control live here.
module uart_tfifo
   import uart_tfifo_pkg::*;
#(
   parameter int FIFO_WIDTH     = UART_FIFO_WIDTH,
   parameter int FIFO_DEPTH     = UART_FIFO_DEPTH,
   parameter int FIFO_POINTER_W = UART_FIFO_POINTER_W,
   parameter int FIFO_COUNTER_W = UART_FIFO_COUNTER_W
) (
   input  logic                      clk,
   input  logic                      wb_rst_i,
   input  logic [FIFO_WIDTH-1:0]     data_in,
   input  logic                      push,
   input  logic                      pop,
   input  logic                      fifo_reset,
   input  logic                      reset_status,
   output logic [FIFO_WIDTH-1:0]     data_out,
   output logic [FIFO_COUNTER_W-1:0] count,
   output logic                      overrun
);

   localparam logic [FIFO_COUNTER_W-1:0] FULL_COUNT = FIFO_COUNTER_W'(FIFO_DEPTH);
   localparam logic [FIFO_POINTER_W-1:0] PTR_ONE    = FIFO_POINTER_W'(1);
   localparam logic [FIFO_COUNTER_W-1:0] CNT_ONE    = FIFO_COUNTER_W'(1);

   logic [FIFO_POINTER_W-1:0] top_reg, top_next;
   logic [FIFO_POINTER_W-1:0] bottom_reg, bottom_next;
   logic [FIFO_COUNTER_W-1:0] count_reg, count_next;
   logic                      overrun_reg, overrun_next;

   logic     fifo_empty;
   logic     fifo_full;
   logic     do_pop;
   logic     do_push;
   logic     mem_we;
   fifo_op_e fifo_op;

   assign fifo_empty = (count_reg == '0);
   assign fifo_full  = (count_reg == FULL_COUNT);

   // A pop on an empty FIFO is ignored. A push into a full FIFO is only
   // accepted when a pop frees the head slot in the same cycle.
   assign do_pop  = pop && !fifo_empty;
   assign do_push = push && (!fifo_full || do_pop);
   assign fifo_op = fifo_op_e'({do_push, do_pop});

   // A flush also blocks the same-cycle write so the pushed word is dropped.
   assign mem_we = do_push && !fifo_reset;

   // Next-state for pointers, count and overrun; flush has top priority.
   always_comb begin
      top_next     = top_reg;
      bottom_next  = bottom_reg;
      count_next   = count_reg;
      overrun_next = overrun_reg;

      if (fifo_reset) begin
         top_next     = '0;
         bottom_next  = '0;
         count_next   = '0;
         overrun_next = 1'b0;
      end else begin
         unique case (fifo_op)
            FIFO_PUSH: begin
               top_next   = top_reg + PTR_ONE;
               count_next = count_reg + CNT_ONE;
            end
            FIFO_POP: begin
               bottom_next = bottom_reg + PTR_ONE;
               count_next  = count_reg - CNT_ONE;
            end
            FIFO_BOTH: begin
               top_next    = top_reg + PTR_ONE;
               bottom_next = bottom_reg + PTR_ONE;
            end
            default: ;
         endcase

         // Clearing the flag wins over a same-cycle overflow.
         if (reset_status)
            overrun_next = 1'b0;
         else if (push && fifo_full && !pop)
            overrun_next = 1'b1;
      end
   end

   // Control state register with asynchronous system reset.
   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         top_reg     <= '0;
         bottom_reg  <= '0;
         count_reg   <= '0;
         overrun_reg <= 1'b0;
      end else begin
         top_reg     <= top_next;
         bottom_reg  <= bottom_next;
         count_reg   <= count_next;
         overrun_reg <= overrun_next;
      end
   end

   uart_tfifo_mem #(
      .WIDTH  (FIFO_WIDTH),
      .DEPTH  (FIFO_DEPTH),
      .ADDR_W (FIFO_POINTER_W)
   ) u_mem (
      .clk      (clk),
      .wb_rst_i (wb_rst_i),
      .we       (mem_we),
      .waddr    (top_reg),
      .wdata    (data_in),
      .raddr    (bottom_reg),
      .rdata    (data_out)
   );

   assign count   = count_reg;
   assign overrun = overrun_reg;

endmodule

// File: tb/tb_uart_tfifo.sv
// Directed self-checking bench for uart_tfifo.
module tb_uart_tfifo;

   logic       clk;
   logic       wb_rst_i;
   logic [7:0] data_in;
   logic       push;
   logic       pop;
   logic       fifo_reset;
   logic       reset_status;
   logic [7:0] data_out;
   logic [4:0] count;
   logic       overrun;

   int n_checks = 0;
   int n_fail   = 0;

   uart_tfifo dut (
      .clk          (clk),
      .wb_rst_i     (wb_rst_i),
      .data_in      (data_in),
      .push         (push),
      .pop          (pop),
      .fifo_reset   (fifo_reset),
      .reset_status (reset_status),
      .data_out     (data_out),
      .count        (count),
      .overrun      (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [7:0] d);
      push = 1'b1;
      data_in = d;
      tick();
      push = 1'b0;
   endtask

   // Check the show-ahead head, then pop it.
   task automatic pop_word(input string tag, input logic [7:0] exp);
      check(tag, data_out, exp);
      pop = 1'b1;
      tick();
      pop = 1'b0;
   endtask

   initial begin
      wb_rst_i = 1'b1;
      data_in = 8'h00;
      push = 1'b0;
      pop = 1'b0;
      fifo_reset = 1'b0;
      reset_status = 1'b0;
      tick();
      tick();
      check("rst_count", count, 0);
      check("rst_overrun", overrun, 0);
      check("rst_data_out", data_out, 0);
      wb_rst_i = 1'b0;
      tick();

      // Single push
      push_word(8'hA5);
      check("push1_count", count, 1);
      check("push1_data", data_out, 8'hA5);
      check("push1_overrun", overrun, 0);
      pop_word("pop1_data", 8'hA5);
      check("pop1_count", count, 0);

      // Fill 16 words (pointers wrap from mid-buffer), then overflow with 0xFF
      for (int i = 1; i <= 16; i++) push_word(8'(i));
      check("full_count", count, 16);
      check("full_overrun", overrun, 0);
      push_word(8'hFF);
      check("ovf_count", count, 16);
      check("ovf_overrun", overrun, 1);
      for (int i = 1; i <= 16; i++) pop_word($sformatf("drain_%0d", i), 8'(i));
      check("drain_count", count, 0);
      pop = 1'b1;
      tick();
      pop = 1'b0;
      check("empty_pop_count", count, 0);
      check("overrun_sticky", overrun, 1);
      reset_status = 1'b1;
      tick();
      reset_status = 1'b0;
      check("reset_status_clr", overrun, 0);

      // Simultaneous push+pop with count=3
      push_word(8'h11);
      push_word(8'h22);
      push_word(8'h33);
      check("three_count", count, 3);
      check("both_head_before", data_out, 8'h11);
      push = 1'b1;
      pop = 1'b1;
      data_in = 8'h55;
      tick();
      push = 1'b0;
      pop = 1'b0;
      check("both_count", count, 3);
      pop_word("both_order_0", 8'h22);
      pop_word("both_order_1", 8'h33);
      pop_word("both_order_2", 8'h55);
      check("both_drain_count", count, 0);

      // Clear wins over same-cycle overflow, then real overflow
      for (int i = 0; i < 16; i++) push_word(8'h80 + 8'(i));
      push = 1'b1;
      reset_status = 1'b1;
      data_in = 8'hEE;
      tick();
      push = 1'b0;
      reset_status = 1'b0;
      check("clear_wins", overrun, 0);
      push_word(8'hEE);
      check("ovf2_overrun", overrun, 1);
      for (int i = 0; i < 9; i++) pop_word($sformatf("part_%0d", i), 8'h80 + 8'(i));
      check("seven_count", count, 7);

      // Flush together with push
      fifo_reset = 1'b1;
      push = 1'b1;
      data_in = 8'hDD;
      tick();
      fifo_reset = 1'b0;
      push = 1'b0;
      check("flush_count", count, 0);
      check("flush_overrun", overrun, 0);
      push_word(8'h77);
      check("post_flush_count", count, 1);
      check("post_flush_data", data_out, 8'h77);
      pop_word("post_flush_pop", 8'h77);

      // Push+pop on empty: push only
      push = 1'b1;
      pop = 1'b1;
      data_in = 8'h99;
      tick();
      push = 1'b0;
      pop = 1'b0;
      check("empty_both_count", count, 1);
      check("empty_both_data", data_out, 8'h99);

      // Async reset mid-stream with overrun set
      for (int i = 0; i < 15; i++) push_word(8'h40 + 8'(i));
      push_word(8'h3C);
      check("pre_arst_count", count, 16);
      check("pre_arst_overrun", overrun, 1);
      #2;
      wb_rst_i = 1'b1;
      #1;
      check("arst_count", count, 0);
      check("arst_overrun", overrun, 0);
      check("arst_data_out", data_out, 0);
      tick();
      wb_rst_i = 1'b0;
      tick();
      push_word(8'h42);
      check("post_arst_count", count, 1);
      check("post_arst_data", data_out, 8'h42);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
